// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: load-data extraction,
// misalignment detection, register-file write control and commit counter.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic [4:0]  mem_WriteRegister,
  input  logic [31:0] mem_ALUResult,
  input  logic [31:0] mem_ReadData,
  input  logic [2:0]  mem_LoadType,
  input  logic        flush,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        wb_valid,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned LTW  = 3;

  localparam logic [LTW-1:0] LT_LB  = 3'b001;
  localparam logic [LTW-1:0] LT_LBU = 3'b010;
  localparam logic [LTW-1:0] LT_LH  = 3'b011;
  localparam logic [LTW-1:0] LT_LHU = 3'b100;

  logic            r_valid;
  logic            r_regwrite;
  logic            r_memtoreg;
  logic [RW-1:0]   r_wreg;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rdata;
  logic [LTW-1:0]  r_ltype;
  logic [XLEN-1:0] r_instr_count;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_is_half;
  logic            w_is_byte;
  logic [XLEN-1:0] w_load_data;
  logic            w_misalign;
  logic            w_commit;

  // Pipeline register; flush inserts a bubble but fields are still captured.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_wreg     <= '0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_ltype    <= '0;
    end else begin
      r_valid    <= mem_valid & ~flush;
      r_regwrite <= mem_RegWrite;
      r_memtoreg <= mem_MemtoReg;
      r_wreg     <= mem_WriteRegister;
      r_alu      <= mem_ALUResult;
      r_rdata    <= mem_ReadData;
      r_ltype    <= mem_LoadType;
    end
  end

  // Little-endian lane selection and sign/zero extension.
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = r_rdata;
    case (r_alu[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_ltype)
      LT_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  w_load_data = {24'h000000, w_byte};
      LT_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  w_load_data = {16'h0000, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  assign w_is_half = (r_ltype == LT_LH) | (r_ltype == LT_LHU);
  assign w_is_byte = (r_ltype == LT_LB) | (r_ltype == LT_LBU);

  // Anything that is neither a byte nor a halfword load is treated as LW.
  assign w_misalign = r_valid & r_memtoreg &
                      ((w_is_half & r_alu[0]) |
                       (~w_is_half & ~w_is_byte & (r_alu[1:0] != 2'b00)));

  assign w_commit = r_valid & ~w_misalign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (w_commit) begin
      r_instr_count <= r_instr_count + XLEN'(1);
    end
  end

  assign wb_valid      = r_valid;
  assign misalign_err  = w_misalign;
  assign RegWrite      = r_valid & r_regwrite & (r_wreg != '0) & ~w_misalign;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_memtoreg ? w_load_data : r_alu;
  assign instr_count   = r_instr_count;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1: synchronous active-low reset.
REQ-004 SHALL have port mem_valid, input, 1: MEM stage holds a valid instruction this cycle.
REQ-005 SHALL have port mem_RegWrite, input, 1: the instruction writes a GPR.
REQ-006 SHALL have port mem_MemtoReg, input, 1: 1 selects load data, 0 selects ALU result.
REQ-007 SHALL have port mem_WriteRegister, input, 5: destination GPR.
REQ-008 SHALL have port mem_ALUResult, input, 32: ALU result, also the load address.
REQ-009 SHALL have port mem_ReadData, input, 32: aligned data-memory word.
REQ-010 SHALL have port mem_LoadType, input, 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes are treated as LW.
REQ-011 SHALL have port flush, input, 1: discard the instruction being captured.
REQ-012 SHALL have port RegWrite, output, 1: write enable to reg_file.
REQ-013 SHALL have port WriteRegister, output, 5: write address to reg_file.
REQ-014 SHALL have port WriteData, output, 32: write data to reg_file.
REQ-015 SHALL have port wb_valid, output, 1: WB holds a valid instruction.
REQ-016 SHALL have port misalign_err, output, 1: the current WB load is misaligned.
REQ-017 SHALL have port instr_count, output, 32: count of committed instructions.

Function
REQ-018 SHALL implement a MEM/WB pipeline register that captures all mem_* fields on every rising clk edge.
REQ-019 SHALL load the stage valid bit with mem_valid & ~flush each edge; flush has priority and inserts a bubble.
REQ-020 SHALL derive WriteData combinationally from the registered fields: ALUResult when MemtoReg=0, otherwise the extracted load data.
REQ-021 SHALL use little-endian byte lanes: byte offset k = ReadData[8k+7:8k], where k = ALUResult[1:0].
REQ-022 SHALL select the byte at offset k for LB/LBU, with LB sign-extended and LBU zero-extended to 32 bits.
REQ-023 SHALL select the halfword at ALUResult[1] (0 = bits 15:0, 1 = bits 31:16) for LH/LHU, with LH sign-extended and LHU zero-extended.
REQ-024 SHALL pass ReadData unchanged for LW.
REQ-025 SHALL assert misalign_err = wb_valid & MemtoReg & ((LH|LHU) & ALUResult[0] | LW & ALUResult[1:0]!=0); LB/LBU are never misaligned.
REQ-026 SHALL drive RegWrite = wb_valid & reg RegWrite & (WriteRegister != 0) & ~misalign_err, so writes to $0 are never issued.
REQ-027 SHALL drive WriteRegister and WriteData from the registered values even when RegWrite=0; their value then has no meaning.
REQ-028 SHALL give one-cycle latency: an instruction presented on mem_* at edge N drives RegWrite, WriteRegister and WriteData during cycle N..N+1, so reg_file commits it at edge N+1.
REQ-029 SHALL increment instr_count by 1 at each edge where wb_valid & ~misalign_err, wrapping from 0xFFFFFFFF to 0.
REQ-030 SHALL count committed non-writing instructions and $0-destination instructions.
REQ-031 SHALL NOT count misaligned loads.
REQ-032 SHALL allow back-to-back valid instructions on consecutive cycles with no bubble.

Reset
REQ-033 SHALL, at an edge with reset=0, clear valid, every stored field and instr_count to 0, regardless of mem_valid or flush.
REQ-034 SHALL hold RegWrite=0, wb_valid=0, misalign_err=0, WriteRegister=0, WriteData=0 and instr_count=0 from the edge after reset=0 is sampled until the first valid capture after release.
REQ-035 SHALL, if reset asserts mid-operation, lose the in-flight WB instruction with no write issued.

Verification
REQ-036 SHALL verify reset: hold reset=0 for 2 cycles while mem_valid=1 -> all outputs 0, instr_count=0.
REQ-037 SHALL verify LW: reg 8, addr 0x100, data 0xDEADBEEF, MemtoReg=1 -> next cycle RegWrite=1, WriteRegister=8, WriteData=0xDEADBEEF, and instr_count=1 after the following edge.
REQ-038 SHALL verify sub-word loads with data 0x80FF1234:
- LB @0x103 -> WriteData=0xFFFFFF80
- LBU @0x103 -> WriteData=0x00000080
- LH @0x102 -> WriteData=0xFFFF80FF
- LHU @0x100 -> WriteData=0x00001234
REQ-039 SHALL verify a $0 write: ALU op with WriteRegister=0, RegWrite=1, ALUResult=0xFFFFFFFF -> RegWrite=0 and instr_count increments.
REQ-040 SHALL verify misalignment: LW @0x102 -> misalign_err=1, RegWrite=0, instr_count unchanged; LH @0x101 behaves the same.
REQ-041 SHALL verify flush and wrap:
- mem_valid=1 with flush=1 -> wb_valid=0 and RegWrite=0 next cycle.
- Back-to-back valid instructions -> two writes on consecutive cycles.
- instr_count forced to 0xFFFFFFFF by committing 2^32-1 instructions -> wraps to 0 on the next commit.
